// File: rtl/fpdiv_seq.sv
// Sequential single-precision divider: restoring divide, one quotient bit per cycle, truncating.
// Optional macro FPDIV_SPECIAL_EN adds zero-operand detection (x/0 -> inf, 0/x -> signed zero).
module fpdiv_seq #(
    parameter int unsigned EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [24:0] rem;
    logic [23:0] dvs;
    logic [24:0] q;
    logic        sign;
    logic [7:0]  expo;
    logic [24:0] diff;
    logic        ge;
    logic        accept;

`ifdef FPDIV_SPECIAL_EN
    logic        spec_hit;
    logic [31:0] spec_val;
`endif

    assign accept = in_valid && in_ready;
    assign ge     = rem >= {1'b0, dvs};
    assign diff   = rem - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = DIV;
            DIV:     if (cnt == 5'd0) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            rem  <= '0;
            dvs  <= '0;
            q    <= '0;
            sign <= 1'b0;
            expo <= '0;
            c    <= '0;
`ifdef FPDIV_SPECIAL_EN
            spec_hit <= 1'b0;
            spec_val <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= a[31] ^ b[31];
                        expo <= a[30:23] - b[30:23] + 8'(EXP_BIAS);
                        rem  <= {2'b01, a[22:0]};
                        dvs  <= {1'b1, b[22:0]};
                        q    <= '0;
                        cnt  <= 5'd24;
`ifdef FPDIV_SPECIAL_EN
                        // Divisor zero wins over dividend zero (0/0 yields infinity).
                        spec_hit <= (b[30:0] == 31'd0) || (a[30:0] == 31'd0);
                        spec_val <= (b[30:0] == 31'd0) ? {a[31] ^ b[31], 8'hFF, 23'h0}
                                                       : {a[31] ^ b[31], 31'h0};
`endif
                    end
                end
                DIV: begin
                    // rem < 2*dvs always holds, so the shifted value fits in 25 bits.
                    if (ge) begin
                        rem <= {diff[23:0], 1'b0};
                        q   <= {q[23:0], 1'b1};
                    end else begin
                        rem <= {rem[23:0], 1'b0};
                        q   <= {q[23:0], 1'b0};
                    end
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                NORM: begin
`ifdef FPDIV_SPECIAL_EN
                    if (spec_hit) begin
                        c <= spec_val;
                    end else
`endif
                    if (q[24]) begin
                        c <= {sign, expo, q[23:1]};
                    end else begin
                        c <= {sign, expo - 8'd1, q[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv_seq.sv
// Directed bench for fpdiv_seq; expected quotients are hand-derived, both macro builds covered.
module tb_fpdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;

    int tests = 0;
    int fails = 0;

    fpdiv_seq #(.EXP_BIAS(127)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Cycle 0 is the cycle whose closing edge accepts the operands; out_valid must appear in cycle 27.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] expc, input int hold, input bit disturb);
        int n;
        a = av;
        b = bv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        step();
        n = 1;
        if (disturb) begin
            a = ~av;
            b = 32'h3F800000;
        end else begin
            in_valid = 1'b0;
        end
        while (!out_valid && n < 100) begin
            step();
            n++;
            if (disturb) a = $urandom;
        end
        in_valid = 1'b0;
        chk({tag, ":latency"}, 32'(n), 32'd27);
        chk({tag, ":c"}, c, expc);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ":hold_c"}, c, expc);
            chk({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ":post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ":post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        step();
        step();
        chk("reset:in_ready", 32'(in_ready), 32'd1);
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:c", c, 32'h0);
        rst = 1'b0;
        step();

        run_op("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 1'b0);
        run_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 1'b1);
        run_op("neg_bp",  32'hC1000000, 32'h40000000, 32'hC0800000, 10, 1'b0);
`ifdef FPDIV_SPECIAL_EN
        run_op("div_by_zero", 32'h40A00000, 32'h00000000, 32'h7F800000, 0, 1'b0);
        run_op("zero_div",    32'h80000000, 32'h40000000, 32'h80000000, 0, 1'b0);
`else
        run_op("div_by_zero", 32'h40A00000, 32'h00000000, 32'h00200000, 0, 1'b0);
        run_op("zero_div",    32'h80000000, 32'h40000000, 32'hFF800000, 0, 1'b0);
`endif

        // Abort in the tenth DIV cycle.
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort:in_ready", 32'(in_ready), 32'd1);
        chk("abort:out_valid", 32'(out_valid), 32'd0);
        chk("abort:c", c, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("abort:no_result", 32'(seen), 32'd0);

        // Reset together with in_valid must not start an operation.
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid || !in_ready) seen++;
        end
        chk("rst_with_valid:idle", 32'(seen), 32'd0);

        run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
